// File: rtl/spi_shift_engine_if.sv
// Transmit/receive handshake bundle between the SPI register front end
// (master side) and the SPI shift engine (slave side).
interface spi_shift_engine_if #(
  parameter int unsigned MAX_BITS = 32
);
  logic [MAX_BITS-1:0] tx_data;
  logic                tx_valid;
  logic                tx_ready;
  logic [MAX_BITS-1:0] rx_data;
  logic                rx_valid;

  // Register front end: offers words to send, collects received words
  modport master (
    output tx_data,
    output tx_valid,
    input  tx_ready,
    input  rx_data,
    input  rx_valid
  );

  // Shift engine: accepts words to send, returns received words
  modport slave (
    input  tx_data,
    input  tx_valid,
    output tx_ready,
    output rx_data,
    output rx_valid
  );
endinterface

// File: rtl/spi_shift_engine.sv
// SPI master shift stage fed by the fractional baud-rate divider.
// Every transition of baud_in is one SCLK half-period ("tick").
// Frames of 1..32 bits are shifted MSB first; CS is held for
// CS_HOLD_TICKS half-periods after the last SCLK edge.
// Optional build macro SPI_LOOPBACK_EN adds a 'loopback' input that
// samples the internal MOSI instead of the MISO pin.
module spi_shift_engine #(
  parameter int unsigned MAX_BITS      = 32,
  parameter int unsigned CS_HOLD_TICKS = 1
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              baud_in,
  spi_shift_engine_if.slave bus,
  input  logic [4:0]        word_size,
  input  logic              cpol,
  input  logic              cpha,
  input  logic              miso,
`ifdef SPI_LOOPBACK_EN
  input  logic              loopback,
`endif
  output logic              sclk,
  output logic              mosi,
  output logic              cs_n,
  output logic              busy
);

  localparam int unsigned CNT_W = $clog2(2 * MAX_BITS + 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_SETUP,
    S_SHIFT,
    S_HOLD
  } state_t;

  state_t              r_state;
  state_t              w_next_state;

  logic                r_baud_q;
  logic                w_tick;

  logic [MAX_BITS-1:0] r_tx_word;
  logic [4:0]          r_ws;
  logic                r_cpol;
  logic                r_cpha;

  logic [CNT_W-1:0]    r_half_cnt;
  logic [4:0]          r_bit_idx;
  logic [3:0]          r_hold_cnt;

  logic [MAX_BITS-1:0] r_rx_shift;
  logic [MAX_BITS-1:0] r_rx_data;
  logic                r_rx_valid;
  logic [MAX_BITS-1:0] w_rx_mask;

  logic                r_sclk;
  logic                r_mosi;
  logic                r_cs_n;

  logic                w_accept;
  logic                w_edge;
  logic                w_lead;
  logic                w_last_edge;
  logic                w_drive;
  logic                w_sample;
  logic                w_sample_bit;
  logic                w_done;
  logic                w_hold_done;

  // A tick is any change of the divider level since the previous clock
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_baud_q <= 1'b0;
    end else begin
      r_baud_q <= baud_in;
    end
  end

  assign w_tick = baud_in ^ r_baud_q;

  assign w_accept    = (r_state == S_IDLE) && bus.tx_valid;
  // Edge number k (1-based) happens while the counter holds 2N-k+1,
  // so an even counter value marks a leading (odd-numbered) edge.
  assign w_edge      = (r_state == S_SHIFT) && w_tick && (r_half_cnt != '0);
  assign w_lead      = ~r_half_cnt[0];
  assign w_last_edge = (r_half_cnt == CNT_W'(1));
  assign w_drive     = w_edge && (r_cpha ? w_lead : (!w_lead && !w_last_edge));
  assign w_sample    = w_edge && (r_cpha ? !w_lead : w_lead);
  assign w_done      = (r_state == S_SHIFT) && (r_half_cnt == '0);
  assign w_hold_done = (r_state == S_HOLD) && w_tick &&
                       (r_hold_cnt == 4'(CS_HOLD_TICKS - 1));

`ifdef SPI_LOOPBACK_EN
  assign w_sample_bit = loopback ? r_mosi : miso;
`else
  assign w_sample_bit = miso;
`endif

  // State register
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Next-state decode; a tick coinciding with acceptance is not seen by SETUP
  always_comb begin
    w_next_state = r_state;
    unique case (r_state)
      S_IDLE:  if (bus.tx_valid) w_next_state = S_SETUP;
      S_SETUP: if (w_tick)       w_next_state = S_SHIFT;
      S_SHIFT: if (w_done)       w_next_state = S_HOLD;
      S_HOLD:  if (w_hold_done)  w_next_state = S_IDLE;
      default:                   w_next_state = S_IDLE;
    endcase
  end

  // Keep only the word_size+1 received bits
  always_comb begin
    w_rx_mask = '0;
    for (int unsigned i = 0; i < MAX_BITS; i++) begin
      w_rx_mask[i] = (i <= 32'(r_ws));
    end
  end

  // Frame capture, bit/edge counting, serial shifting and pin registers
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_tx_word  <= '0;
      r_ws       <= '0;
      r_cpol     <= 1'b0;
      r_cpha     <= 1'b0;
      r_half_cnt <= '0;
      r_bit_idx  <= '0;
      r_hold_cnt <= '0;
      r_rx_shift <= '0;
      r_rx_data  <= '0;
      r_rx_valid <= 1'b0;
      r_sclk     <= 1'b0;
      r_mosi     <= 1'b0;
      r_cs_n     <= 1'b1;
    end else begin
      r_rx_valid <= 1'b0;
      unique case (r_state)
        S_IDLE: begin
          r_sclk <= cpol;
          if (w_accept) begin
            r_tx_word  <= bus.tx_data;
            r_ws       <= word_size;
            r_cpol     <= cpol;
            r_cpha     <= cpha;
            r_cs_n     <= 1'b0;
            r_half_cnt <= (CNT_W'(word_size) + CNT_W'(1)) << 1;
            r_hold_cnt <= '0;
            r_rx_shift <= '0;
            // With cpha=0 the first bit must be on the wire before the
            // leading edge, so it goes out together with CS.
            if (cpha) begin
              r_bit_idx <= word_size;
            end else begin
              r_bit_idx <= word_size - 5'd1;
              r_mosi    <= bus.tx_data[word_size];
            end
          end
        end
        S_SETUP: begin
        end
        S_SHIFT: begin
          if (w_edge) begin
            r_sclk     <= ~r_sclk;
            r_half_cnt <= r_half_cnt - CNT_W'(1);
            if (w_drive) begin
              r_mosi    <= r_tx_word[r_bit_idx];
              r_bit_idx <= r_bit_idx - 5'd1;
            end
            if (w_sample) begin
              r_rx_shift <= {r_rx_shift[MAX_BITS-2:0], w_sample_bit};
            end
          end else if (w_done) begin
            r_rx_valid <= 1'b1;
            r_rx_data  <= r_rx_shift & w_rx_mask;
            r_sclk     <= r_cpol;
            r_hold_cnt <= '0;
          end
        end
        S_HOLD: begin
          if (w_tick) begin
            if (w_hold_done) begin
              r_cs_n <= 1'b1;
            end else begin
              r_hold_cnt <= r_hold_cnt + 4'd1;
            end
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign bus.tx_ready = (r_state == S_IDLE);
  assign bus.rx_data  = r_rx_data;
  assign bus.rx_valid = r_rx_valid;
  assign busy         = (r_state != S_IDLE);
  assign sclk         = r_sclk;
  assign mosi         = r_mosi;
  assign cs_n         = r_cs_n;

endmodule

// File: tb/tb_spi_shift_engine.sv
// Self-checking bench for spi_shift_engine: baud generator, SPI slave
// model, and a scoreboard of expected received words.
`timescale 1ns/1ps
module tb_spi_shift_engine;
  localparam int unsigned MAX_BITS = 32;
  localparam int unsigned HOLD     = 1;
  localparam int          BAUD_DIV = 4;
  localparam int          LIMIT    = 3000;

  logic       clock, reset, baud_in, cpol, cpha, miso, sclk, mosi, cs_n, busy;
  logic [4:0] word_size;
  logic       use_loop, slave_miso, baud_en, abort_flag;

  spi_shift_engine_if #(.MAX_BITS(MAX_BITS)) bus();

  assign miso = use_loop ? mosi : slave_miso;

  spi_shift_engine #(.MAX_BITS(MAX_BITS), .CS_HOLD_TICKS(HOLD)) dut (
    .clock(clock), .reset(reset), .baud_in(baud_in), .bus(bus),
    .word_size(word_size), .cpol(cpol), .cpha(cpha), .miso(miso),
`ifdef SPI_LOOPBACK_EN
    .loopback(1'b0),
`endif
    .sclk(sclk), .mosi(mosi), .cs_n(cs_n), .busy(busy)
  );

  int          checks, errors;
  int          cyc, last_edge_cyc, edge_cnt, rx_cnt, rx_mark, div;
  int          s_idx, s_edges;
  logic [31:0] mosi_cap, slave_word, exp_w;
  logic [4:0]  ws_cfg;
  logic        cpha_cfg, prev_sclk, prev_cs, prev_mosi;
  logic [31:0] exp_q[$];

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached, required finish earlier");
    $fatal(1, "watchdog");
  end

  // Divider model: baud_in toggles every BAUD_DIV clocks while enabled
  initial begin
    div = 0;
    forever begin
      @(negedge clock);
      if (baud_en) begin
        div++;
        if (div >= BAUD_DIV) begin
          div = 0;
          baud_in = ~baud_in;
        end
      end
    end
  end

  // Monitor: scoreboard, SPI slave model, edge counting, CS hold timing
  initial begin
    cyc = 0; last_edge_cyc = 0; edge_cnt = 0; rx_cnt = 0; mosi_cap = '0;
    s_idx = 0; s_edges = 0;
    prev_sclk = 1'b0; prev_cs = 1'b1; prev_mosi = 1'b0;
    forever begin
      @(negedge clock);
      cyc++;
      if (reset) begin
        prev_sclk = sclk; prev_cs = cs_n; prev_mosi = mosi;
        continue;
      end
      if (bus.rx_valid) begin
        rx_cnt++;
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL rx_unexpected: rx_valid with rx_data=%h, required no pulse", bus.rx_data);
        end else begin
          exp_w = exp_q.pop_front();
          if (bus.rx_data !== exp_w) begin
            errors++;
            $display("FAIL rx_data: got %h, required %h", bus.rx_data, exp_w);
          end
        end
      end
      if (prev_cs && !cs_n) begin
        s_idx = int'(ws_cfg); s_edges = 0;
        if (!cpha_cfg) slave_miso = slave_word[s_idx];
      end else if (!cs_n && sclk !== prev_sclk) begin
        s_edges++;
        if (!cpha_cfg && (s_edges % 2 == 0) && s_idx > 0) begin
          s_idx--;
          slave_miso = slave_word[s_idx];
        end else if (cpha_cfg && (s_edges % 2 == 1)) begin
          slave_miso = slave_word[s_idx];
          if (s_idx > 0) s_idx--;
        end
      end
      if (sclk !== prev_sclk && (!cs_n || !prev_cs)) begin
        edge_cnt++;
        last_edge_cyc = cyc;
        if (!prev_sclk && sclk) mosi_cap = {mosi_cap[30:0], prev_mosi};
      end
      if (!prev_cs && cs_n && !abort_flag) begin
        checks++;
        if (cyc - last_edge_cyc != BAUD_DIV * int'(HOLD)) begin
          errors++;
          $display("FAIL cs_hold: cs_n rose %0d clocks after last edge, required %0d",
                   cyc - last_edge_cyc, BAUD_DIV * int'(HOLD));
        end
      end
      prev_sclk = sclk; prev_cs = cs_n; prev_mosi = mosi;
    end
  end

  task automatic start_frame(input logic [31:0] data, input logic [4:0] ws,
                             input logic pol, input logic pha,
                             input logic push, input logic [31:0] exp_rx);
    int n = 0;
    @(negedge clock);
    while (!bus.tx_ready && n < LIMIT) begin @(negedge clock); n++; end
    checks++;
    if (!bus.tx_ready) begin
      errors++;
      $display("FAIL start_ready: tx_ready=%b, required 1", bus.tx_ready);
    end
    ws_cfg = ws; cpha_cfg = pha;
    word_size = ws; cpol = pol; cpha = pha;
    @(negedge clock);
    @(negedge clock);
    edge_cnt = 0; mosi_cap = '0; rx_mark = rx_cnt;
    bus.tx_data = data; bus.tx_valid = 1'b1;
    if (push) exp_q.push_back(exp_rx);
    @(negedge clock);
    bus.tx_valid = 1'b0;
    checks++;
    if (cs_n !== 1'b0 || busy !== 1'b1) begin
      errors++;
      $display("FAIL accept: cs_n=%b busy=%b, required cs_n=0 busy=1", cs_n, busy);
    end
  endtask

  task automatic wait_done(input int rx_before);
    int n = 0;
    while (rx_cnt == rx_before && n < LIMIT) begin @(negedge clock); n++; end
    checks++;
    if (rx_cnt == rx_before) begin
      errors++;
      $display("FAIL rx_timeout: no rx_valid within %0d clocks, required one", LIMIT);
    end
    n = 0;
    while (cs_n !== 1'b1 && n < LIMIT) begin @(negedge clock); n++; end
    checks++;
    if (cs_n !== 1'b1) begin
      errors++;
      $display("FAIL cs_timeout: cs_n=%b, required 1", cs_n);
    end
  endtask

  task automatic wait_edges(input int target);
    int n = 0;
    while (edge_cnt < target && n < LIMIT) begin @(negedge clock); n++; end
    checks++;
    if (edge_cnt < target) begin
      errors++;
      $display("FAIL edge_timeout: %0d edges, required %0d", edge_cnt, target);
    end
  endtask

  task automatic test_reset;
    reset = 1'b1;
    repeat (3) @(negedge clock);
    checks++;
    if (sclk !== 1'b0 || mosi !== 1'b0 || cs_n !== 1'b1 || bus.rx_data !== '0 ||
        bus.rx_valid !== 1'b0 || bus.tx_ready !== 1'b1 || busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_state: sclk=%b mosi=%b cs_n=%b rx=%h rxv=%b rdy=%b busy=%b, required 0 0 1 0 0 1 0",
               sclk, mosi, cs_n, bus.rx_data, bus.rx_valid, bus.tx_ready, busy);
    end
    reset = 1'b0;
    repeat (2) @(negedge clock);
  endtask

  task automatic test_mode0;
    use_loop = 1'b0; slave_word = 32'h0000003C;
    start_frame(32'h000000A5, 5'd7, 1'b0, 1'b0, 1'b1, 32'h0000003C);
    wait_done(rx_mark);
    checks++;
    if (edge_cnt != 16) begin errors++; $display("FAIL m0_edges: got %0d, required 16", edge_cnt); end
    checks++;
    if (mosi_cap[7:0] !== 8'hA5) begin errors++; $display("FAIL m0_mosi: got %h, required a5", mosi_cap[7:0]); end
    checks++;
    if (rx_cnt - rx_mark != 1) begin errors++; $display("FAIL m0_pulses: got %0d, required 1", rx_cnt - rx_mark); end
  endtask

  task automatic test_mode3;
    use_loop = 1'b1;
    cpol = 1'b1;
    repeat (3) @(negedge clock);
    checks++;
    if (sclk !== 1'b1) begin errors++; $display("FAIL m3_idle: sclk=%b, required 1", sclk); end
    start_frame(32'hDEADBEEF, 5'd31, 1'b1, 1'b1, 1'b1, 32'hDEADBEEF);
    wait_done(rx_mark);
    checks++;
    if (edge_cnt != 64) begin errors++; $display("FAIL m3_edges: got %0d, required 64", edge_cnt); end
    checks++;
    if (mosi_cap !== 32'hDEADBEEF) begin errors++; $display("FAIL m3_mosi: got %h, required deadbeef", mosi_cap); end
    checks++;
    if (sclk !== 1'b1) begin errors++; $display("FAIL m3_end_idle: sclk=%b, required 1", sclk); end
  endtask

  task automatic test_single_bit;
    use_loop = 1'b0; slave_word = 32'hFFFFFFFF;
    start_frame(32'hFFFFFFFE, 5'd0, 1'b0, 1'b0, 1'b1, 32'h00000001);
    wait_done(rx_mark);
    checks++;
    if (edge_cnt != 2) begin errors++; $display("FAIL w1_edges: got %0d, required 2", edge_cnt); end
    checks++;
    if (mosi_cap[0] !== 1'b0) begin errors++; $display("FAIL w1_mosi: got %b, required 0", mosi_cap[0]); end
    checks++;
    if (bus.rx_data[31:1] !== 31'd0) begin errors++; $display("FAIL w1_upper: got %h, required 0", bus.rx_data[31:1]); end
  endtask

  task automatic test_back_to_back;
    int n = 0;
    use_loop = 1'b1;
    start_frame(32'h00000096, 5'd7, 1'b0, 1'b0, 1'b1, 32'h00000096);
    bus.tx_valid = 1'b1;
    wait_edges(3);
    bus.tx_data = 32'h0000A1C3;
    word_size = 5'd15; ws_cfg = 5'd15;
    exp_q.push_back(32'h0000A1C3);
    while (cs_n !== 1'b1 && n < LIMIT) begin @(negedge clock); n++; end
    checks++;
    if (cs_n !== 1'b1 || bus.tx_ready !== 1'b1 || busy !== 1'b0) begin
      errors++;
      $display("FAIL b2b_gap: cs_n=%b rdy=%b busy=%b, required 1 1 0", cs_n, bus.tx_ready, busy);
    end
    checks++;
    if (edge_cnt != 16 || mosi_cap[7:0] !== 8'h96) begin
      errors++;
      $display("FAIL b2b_first: edges=%0d mosi=%h, required 16 96", edge_cnt, mosi_cap[7:0]);
    end
    edge_cnt = 0; mosi_cap = '0; rx_mark = rx_cnt;
    @(negedge clock);
    bus.tx_valid = 1'b0;
    checks++;
    if (cs_n !== 1'b0 || busy !== 1'b1) begin
      errors++;
      $display("FAIL b2b_second_start: cs_n=%b busy=%b, required 0 1", cs_n, busy);
    end
    wait_done(rx_mark);
    checks++;
    if (edge_cnt != 32 || mosi_cap[15:0] !== 16'hA1C3) begin
      errors++;
      $display("FAIL b2b_second: edges=%0d mosi=%h, required 32 a1c3", edge_cnt, mosi_cap[15:0]);
    end
  endtask

  task automatic test_reset_midframe;
    use_loop = 1'b0; slave_word = 32'h0000003C;
    start_frame(32'h000000A5, 5'd7, 1'b0, 1'b0, 1'b0, 32'h0);
    wait_edges(5);
    abort_flag = 1'b1;
    reset = 1'b1;
    #1;
    checks++;
    if (cs_n !== 1'b1 || sclk !== 1'b0) begin
      errors++;
      $display("FAIL rst_mid: cs_n=%b sclk=%b, required 1 0", cs_n, sclk);
    end
    repeat (2) @(negedge clock);
    reset = 1'b0;
    @(negedge clock);
    checks++;
    if (bus.tx_ready !== 1'b1 || busy !== 1'b0) begin
      errors++;
      $display("FAIL rst_ready: rdy=%b busy=%b, required 1 0", bus.tx_ready, busy);
    end
    repeat (150) @(negedge clock);
    checks++;
    if (rx_cnt != rx_mark) begin
      errors++;
      $display("FAIL rst_rx: %0d rx pulses, required 0", rx_cnt - rx_mark);
    end
    abort_flag = 1'b0;
  endtask

  task automatic test_stall;
    logic s0, m0, c0, moved;
    use_loop = 1'b1;
    start_frame(32'h0000005A, 5'd7, 1'b0, 1'b0, 1'b1, 32'h0000005A);
    wait_edges(6);
    baud_en = 1'b0;
    @(negedge clock);
    @(negedge clock);
    s0 = sclk; m0 = mosi; c0 = cs_n; moved = 1'b0;
    repeat (100) begin
      @(negedge clock);
      if (sclk !== s0 || mosi !== m0 || cs_n !== c0) moved = 1'b1;
    end
    checks++;
    if (moved || c0 !== 1'b0) begin
      errors++;
      $display("FAIL stall_stable: moved=%b cs_n=%b, required 0 0", moved, c0);
    end
    baud_en = 1'b1;
    wait_done(rx_mark);
    checks++;
    if (edge_cnt != 16 || mosi_cap[7:0] !== 8'h5A) begin
      errors++;
      $display("FAIL stall_resume: edges=%0d mosi=%h, required 16 5a", edge_cnt, mosi_cap[7:0]);
    end
  endtask

  initial begin
    checks = 0; errors = 0;
    reset = 1'b1; baud_in = 1'b0; cpol = 1'b0; cpha = 1'b0; word_size = '0;
    bus.tx_data = '0; bus.tx_valid = 1'b0;
    use_loop = 1'b0; slave_miso = 1'b0; slave_word = '0; baud_en = 1'b1; abort_flag = 1'b0;
    ws_cfg = '0; cpha_cfg = 1'b0; rx_mark = 0;
    test_reset();
    test_mode0();
    test_mode3();
    test_single_bit();
    test_back_to_back();
    test_reset_midframe();
    test_stall();
    repeat (5) @(negedge clock);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_left: %0d words outstanding, required 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
